i2c_reg_sequencer: RTL and testbench
====================================

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000; max clk cycles allowed per master command before abort.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  start one register transaction; accepted only while busy=0.
REQ-005 SHALL have port rw  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have port dev_addr  input  7  7-bit I2C slave address.
REQ-007 SHALL have port reg_addr  input  8  slave register index.
REQ-008 SHALL have port wdata  input  8  write payload.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port err  output  2  result code valid with done: 00 ok, 01 address NACK, 10 register/data NACK, 11 timeout.
REQ-012 SHALL have port rdata  output  8  read result, valid with done when rw=1 and err=00.
REQ-013 SHALL have ports m_start, m_stop, m_write, m_read  output  1 each  one-cycle command pulses to the I2C master.
REQ-014 SHALL have port m_data_in  output  8  byte for m_write.
REQ-015 SHALL have port m_ack_in  output  1  ACK/NACK level the master drives after m_read (1 = NACK).
REQ-016 SHALL have ports m_done, m_busy, m_ack_err  input  1 each; m_data_out  input  8; from the I2C master.

Function
REQ-017 SHALL latch rw, dev_addr, reg_addr, wdata on the cycle req=1 and busy=0; busy SHALL be 1 from the next cycle until the cycle after done; req while busy=1 SHALL be ignored.
REQ-018 SHALL execute write as: START, WRITE {dev_addr,0}, WRITE reg_addr, WRITE wdata, STOP.
REQ-019 SHALL execute read as: START, WRITE {dev_addr,0}, WRITE reg_addr, START (repeated), WRITE {dev_addr,1}, READ with m_ack_in=1, STOP.
REQ-020 SHALL use states IDLE, ISSUE, WAIT, STOP_ISSUE, STOP_WAIT, FINISH plus a 3-bit step index selecting the current command.
REQ-021 ISSUE SHALL wait until m_busy=0, then assert exactly one command pulse for one cycle and go to WAIT; never more than one command outstanding.
REQ-022 m_data_in and m_ack_in SHALL be held stable from the command pulse until m_done.
REQ-023 In WAIT, m_done on a WRITE with m_ack_err=1 SHALL set err (01 for step 1 and the read-address write, 10 otherwise) and go to STOP_ISSUE, skipping the remaining steps.
REQ-024 m_done on READ SHALL capture m_data_out into rdata; m_ack_err on READ SHALL be ignored.
REQ-025 A 17-bit (or wider for TIMEOUT_CYCLES) counter SHALL clear on every command pulse; reaching TIMEOUT_CYCLES in WAIT SHALL set err=11 and go to STOP_ISSUE; in STOP_WAIT it SHALL set err=11 and go to FINISH.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE; done-to-next-accept latency is one cycle.
REQ-027 err SHALL record the first error only; rdata SHALL retain its last value when not updated.

Reset
REQ-028 On reset: state IDLE, busy=0, done=0, err=00, rdata=0x00, all m_* command pulses 0, m_data_in=0x00, m_ack_in=0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL abort without issuing STOP; bus recovery is the master's reset responsibility.

Structure
REQ-030 Error codes, state encoding and command step encoding SHALL live in shared package i2c_pkg.
REQ-031 Timeout counter MAY be sub-module i2c_cmd_timer; no other sub-modules; top_i2c-level integration instantiates sequencer beside the master.

Verification
REQ-032 Write dev 0x50 reg 0x10 data 0xA5, slave ACKs all -> commands START,W 0xA0,W 0x10,W 0xA5,STOP; done with err=00.
REQ-033 Read dev 0x50 reg 0x10, slave returns 0x3C -> START,W 0xA0,W 0x10,START,W 0xA1,READ (ack_in=1),STOP; rdata=0x3C, err=00.
REQ-034 Write to absent dev 0x23 (address NACK) -> START,W 0x46,STOP only; err=01.
REQ-035 Master model withholds m_done after W reg_addr, TIMEOUT_CYCLES=64 -> STOP issued 64 cycles after pulse; err=11.
REQ-036 req asserted while busy, and reset asserted mid-read -> second req ignored; after reset busy=0, done never pulses, next req runs normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register sequencer: FSM states, result codes,
// master command kinds and the per-step command/byte selection.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StIssue     = 3'd1,
        StWait      = 3'd2,
        StStopIssue = 3'd3,
        StStopWait  = 3'd4,
        StFinish    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ErrOk       = 2'b00,
        ErrAddrNack = 2'b01,
        ErrDataNack = 2'b10,
        ErrTimeout  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        CmdStart = 2'd0,
        CmdWrite = 2'd1,
        CmdRead  = 2'd2
    } cmd_e;

    // Step indices. A write runs steps 0..3, a read runs steps 0..5; STOP is
    // issued from its own state rather than as a step.
    localparam logic [2:0] StepStart   = 3'd0;
    localparam logic [2:0] StepDevW    = 3'd1;
    localparam logic [2:0] StepReg     = 3'd2;
    localparam logic [2:0] StepData    = 3'd3;
    localparam logic [2:0] StepRestart = 3'd3;
    localparam logic [2:0] StepDevR    = 3'd4;
    localparam logic [2:0] StepRead    = 3'd5;

    function automatic cmd_e step_cmd(input logic rw, input logic [2:0] step);
        cmd_e c;
        c = CmdWrite;
        if (step == StepStart || (rw && step == StepRestart)) begin
            c = CmdStart;
        end else if (rw && step == StepRead) begin
            c = CmdRead;
        end
        return c;
    endfunction

    function automatic logic [7:0] step_byte(input logic       rw,
                                             input logic [2:0] step,
                                             input logic [6:0] dev,
                                             input logic [7:0] radr,
                                             input logic [7:0] wbyte);
        logic [7:0] b;
        b = wbyte;
        if (step == StepDevW) begin
            b = {dev, 1'b0};
        end else if (step == StepReg) begin
            b = radr;
        end else if (rw && step == StepDevR) begin
            b = {dev, 1'b1};
        end
        return b;
    endfunction

    function automatic logic is_last_step(input logic rw, input logic [2:0] step);
        return rw ? (step == StepRead) : (step == StepData);
    endfunction

    // Address bytes NACK as "device absent"; every other byte is a data NACK.
    function automatic logic is_addr_step(input logic rw, input logic [2:0] step);
        return (step == StepDevW) || (rw && step == StepDevR);
    endfunction

endpackage

// File: rtl/i2c_cmd_timer.sv
// Per-command watchdog: cleared as each command pulse is launched, counts while
// the sequencer waits on the master, flags expiry at the TIMEOUT_CYCLES budget.
module i2c_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned ClogW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW  = (ClogW > 17) ? ClogW : 17;

    // The counter reads 0 in the cycle the command pulse is high. Expiry is
    // raised two counts early so that, after the state hop and the registered
    // STOP pulse, STOP lands exactly TIMEOUT_CYCLES after the abandoned pulse.
    // TIMEOUT_CYCLES must be at least 2.
    localparam logic [CntW-1:0] ExpireAt = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] count_q;

    // Count cycles spent waiting on the master, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = enable && (count_q >= ExpireAt);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-level I2C sequencer: turns one register read/write request into the
// START / WRITE / READ / STOP command stream for a byte-level I2C master.
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    // register transaction request
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] rdata,
    // byte-level I2C master command interface
    output logic       m_start,
    output logic       m_stop,
    output logic       m_write,
    output logic       m_read,
    output logic [7:0] m_data_in,
    output logic       m_ack_in,
    input  logic       m_done,
    input  logic       m_busy,
    input  logic       m_ack_err,
    input  logic [7:0] m_data_out
);

    state_e     state_q;
    logic [2:0] step_q;
    cmd_e       cmd_q;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;

    cmd_e       cur_cmd;
    logic [7:0] cur_byte;
    logic       issue_fire;
    logic       stop_fire;
    logic       tmr_en;
    logic       tmr_expired;

    assign cur_cmd  = step_cmd(rw_q, step_q);
    assign cur_byte = step_byte(rw_q, step_q, dev_q, reg_q, wdata_q);

    assign issue_fire = (state_q == StIssue) && !m_busy;
    // After a timeout the master may never report idle again, so STOP goes out
    // regardless of m_busy in that case; the abandoned command is written off.
    assign stop_fire  = (state_q == StStopIssue) && (!m_busy || (err == ErrTimeout));
    assign tmr_en     = (state_q == StWait) || (state_q == StStopWait);

    i2c_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cmd_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (issue_fire || stop_fire),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            step_q    <= StepStart;
            cmd_q     <= CmdStart;
            rw_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ErrOk;
            rdata     <= '0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_write   <= 1'b0;
            m_read    <= 1'b0;
            m_data_in <= '0;
            m_ack_in  <= 1'b0;
        end else begin
            done    <= 1'b0;
            m_start <= 1'b0;
            m_stop  <= 1'b0;
            m_write <= 1'b0;
            m_read  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        rw_q    <= rw;
                        dev_q   <= dev_addr;
                        reg_q   <= reg_addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        err     <= ErrOk;
                        step_q  <= StepStart;
                        state_q <= StIssue;
                    end
                end

                StIssue: begin
                    if (issue_fire) begin
                        unique case (cur_cmd)
                            CmdStart: m_start <= 1'b1;
                            CmdWrite: begin
                                m_write   <= 1'b1;
                                m_data_in <= cur_byte;
                            end
                            CmdRead:  m_read <= 1'b1;
                            default:  m_start <= 1'b1;
                        endcase
                        // Single-byte reads always finish with NACK.
                        m_ack_in <= (cur_cmd == CmdRead);
                        cmd_q    <= cur_cmd;
                        state_q  <= StWait;
                    end
                end

                StWait: begin
                    if (m_done) begin
                        if ((cmd_q == CmdWrite) && m_ack_err) begin
                            err     <= is_addr_step(rw_q, step_q) ? ErrAddrNack : ErrDataNack;
                            state_q <= StStopIssue;
                        end else begin
                            if (cmd_q == CmdRead) begin
                                rdata <= m_data_out;
                            end
                            if (is_last_step(rw_q, step_q)) begin
                                state_q <= StStopIssue;
                            end else begin
                                step_q  <= step_q + 3'd1;
                                state_q <= StIssue;
                            end
                        end
                    end else if (tmr_expired) begin
                        err     <= ErrTimeout;
                        state_q <= StStopIssue;
                    end
                end

                StStopIssue: begin
                    if (stop_fire) begin
                        m_stop   <= 1'b1;
                        m_ack_in <= 1'b0;
                        state_q  <= StStopWait;
                    end
                end

                StStopWait: begin
                    if (m_done) begin
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end else if (tmr_expired) begin
                        // Keep an earlier NACK code; only the first error is reported.
                        if (err == ErrOk) begin
                            err <= ErrTimeout;
                        end
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end
                end

                StFinish: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: a byte-level I2C master/slave
// model answers the command stream, and each register transaction is checked
// against the command list, result code and read data the protocol implies.
module tb_i2c_reg_sequencer;

    localparam int unsigned TO = 64;

    localparam int KStart = 0;
    localparam int KWrite = 1;
    localparam int KRead  = 2;
    localparam int KStop  = 3;

    typedef struct {
        int kind;
        int data;
        int ack;
        int cyc;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [7:0] rdata;
    logic       m_start;
    logic       m_stop;
    logic       m_write;
    logic       m_read;
    logic [7:0] m_data_in;
    logic       m_ack_in;
    logic       m_done;
    logic       m_busy;
    logic       m_ack_err;
    logic [7:0] m_data_out;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rw        (rw),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .m_start   (m_start),
        .m_stop    (m_stop),
        .m_write   (m_write),
        .m_read    (m_read),
        .m_data_in (m_data_in),
        .m_ack_in  (m_ack_in),
        .m_done    (m_done),
        .m_busy    (m_busy),
        .m_ack_err (m_ack_err),
        .m_data_out(m_data_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour for the current transaction (written by the stimulus only).
    bit         cfg_absent;
    bit         cfg_dnack;
    bit         cfg_stall;
    logic [7:0] cfg_rbyte;

    // Commands seen by the master model (written by the model only).
    cmd_t log_q[$];

    // Master/slave model: one command at a time, done after a random delay.
    initial begin : master_model
        int         np;
        int         left;
        int         wr_total;
        int         wr_since_start;
        bit         stalled;
        bit         pend_nack;
        bit         pend_rd;
        bit         held_wr;
        logic [7:0] held_data;
        logic       held_ack;
        cmd_t       e;
        m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0; m_data_out = 8'h00;
        left = 0; wr_total = 0; wr_since_start = 0; stalled = 1'b0;
        pend_nack = 1'b0; pend_rd = 1'b0; held_wr = 1'b0; held_data = 8'h00; held_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0;
                stalled = 1'b0; wr_total = 0; wr_since_start = 0;
            end else begin
                if (m_done) begin
                    m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0;
                end
                np = int'(m_start) + int'(m_stop) + int'(m_write) + int'(m_read);
                if (np != 0) begin
                    check_eq("single_pulse", np, 1);
                    check_eq("cmd_while_busy", m_busy && !stalled, 0);
                    e.kind = m_start ? KStart : m_write ? KWrite : m_read ? KRead : KStop;
                    e.data = m_write ? int'(m_data_in) : 0;
                    e.ack  = int'(m_ack_in);
                    e.cyc  = cyc;
                    log_q.push_back(e);
                    pend_nack = 1'b0;
                    stalled   = 1'b0;
                    if (m_start) wr_since_start = 0;
                    if (m_write) begin
                        wr_total++;
                        if (wr_since_start == 0 && cfg_absent) pend_nack = 1'b1;
                        if (wr_total == 2 && cfg_dnack) pend_nack = 1'b1;
                        if (wr_total == 2 && cfg_stall) stalled = 1'b1;
                        wr_since_start++;
                    end
                    if (m_stop) begin
                        wr_total = 0;
                        wr_since_start = 0;
                    end
                    pend_rd   = m_read;
                    held_wr   = m_write;
                    held_data = m_data_in;
                    held_ack  = m_ack_in;
                    m_busy    = 1'b1;
                    left      = $urandom_range(1, 4);
                end else if (m_busy && !stalled) begin
                    if (held_wr) check_eq("data_in_stable", m_data_in, held_data);
                    if (pend_rd) check_eq("ack_in_stable", m_ack_in, held_ack);
                    left--;
                    if (left == 0) begin
                        m_done     = 1'b1;
                        // NACK after a read is the sequencer's own doing; noise here must be ignored.
                        m_ack_err  = pend_rd ? 1'($urandom_range(0, 1)) : pend_nack;
                        m_data_out = pend_rd ? cfg_rbyte : 8'($urandom);
                    end
                end
            end
        end
    end

    logic [7:0] exp_rdata = 8'h00;

    task automatic push_cmd(inout cmd_t q[$], input int kind, input int data, input int ack);
        cmd_t e;
        e.kind = kind; e.data = data; e.ack = ack; e.cyc = 0;
        q.push_back(e);
    endtask

    task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [7:0] wd, input logic [7:0] rb,
                           input bit absent, input bit dnack, input bit stall, input bit poke);
        cmd_t       exp_q[$];
        logic [1:0] exp_err;
        int         base;
        int         n;
        int         got_n;
        bit         got_done;
        cfg_absent = absent; cfg_dnack = dnack; cfg_stall = stall; cfg_rbyte = rb;
        base = log_q.size();

        // Expected command stream from the register-access protocol.
        exp_err = 2'b00;
        push_cmd(exp_q, KStart, 0, 0);
        push_cmd(exp_q, KWrite, {d, 1'b0}, 0);
        if (absent) begin
            exp_err = 2'b01;
        end else begin
            push_cmd(exp_q, KWrite, ra, 0);
            if (stall) begin
                exp_err = 2'b11;
            end else if (dnack) begin
                exp_err = 2'b10;
            end else if (!r) begin
                push_cmd(exp_q, KWrite, wd, 0);
            end else begin
                push_cmd(exp_q, KStart, 0, 0);
                push_cmd(exp_q, KWrite, {d, 1'b1}, 0);
                push_cmd(exp_q, KRead, 0, 1);
            end
        end
        push_cmd(exp_q, KStop, 0, 0);
        if (exp_err == 2'b00 && r) exp_rdata = rb;

        req = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        // Scramble the request fields: the sequencer must work from its latched copy.
        rw = 1'($urandom); dev_addr = 7'($urandom); reg_addr = 8'($urandom); wdata = 8'($urandom);
        check_eq("busy_after_req", busy, 1);

        n = 0;
        got_done = 1'b0;
        while (!got_done && n < 3000) begin
            if (n == 3 && poke) begin
                req = 1'b1; rw = ~r; dev_addr = ~d; reg_addr = ~ra; wdata = ~wd;
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) got_done = 1'b1;
            else if (!got_done) check_eq("busy_until_done", busy, 1);
        end
        req = 1'b0;
        check_eq("done_seen", got_done, 1);
        check_eq("err", err, exp_err);
        check_eq("rdata", rdata, exp_rdata);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_cleared", busy, 0);

        got_n = log_q.size() - base;
        check_eq("cmd_count", got_n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            check_eq($sformatf("cmd%0d_kind", i), log_q[base+i].kind, exp_q[i].kind);
            if (exp_q[i].kind == KWrite)
                check_eq($sformatf("cmd%0d_byte", i), log_q[base+i].data, exp_q[i].data);
            if (exp_q[i].kind == KRead)
                check_eq($sformatf("cmd%0d_ack_in", i), log_q[base+i].ack, exp_q[i].ack);
        end
        if (stall && got_n >= 4)
            check_eq("timeout_stop_gap", log_q[base+3].cyc - log_q[base+2].cyc, TO);
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int   sel;
        int   base;
        bit   seen;
        req = 1'b0; rw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0;
        cfg_absent = 1'b0; cfg_dnack = 1'b0; cfg_stall = 1'b0; cfg_rbyte = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_pulses", {m_start, m_stop, m_write, m_read}, 0);
        check_eq("rst_data_in", m_data_in, 0);
        check_eq("rst_ack_in", m_ack_in, 0);
        @(posedge clk);
        #1;

        // Directed protocol cases.
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 7'h23, 8'h10, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 7'h50, 8'h20, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        run_txn(1'b1, 7'h51, 8'h22, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(1'b1, 7'h50, 8'h31, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a read: abort silently, no STOP.
        cfg_absent = 1'b0; cfg_dnack = 1'b0; cfg_stall = 1'b0; cfg_rbyte = 8'hE7;
        req = 1'b1; rw = 1'b1; dev_addr = 7'h50; reg_addr = 8'h44;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rdata = 8'h00;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_rdata", rdata, 0);
        check_eq("mid_rst_data_in", m_data_in, 0);
        base = log_q.size();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check_eq("mid_rst_quiet", seen, 0);
        check_eq("mid_rst_no_cmds", log_q.size() - base, 0);
        run_txn(1'b1, 7'h50, 8'h44, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized transactions with occasional faults and ignored requests.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 11);
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    sel == 0, sel == 1, sel == 2, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
